// File: rtl/y86_dmem_responder.sv
// Single-outstanding data-memory responder for the Y86 memory stage, with configurable access latency.
// Define DMEM_ALIGN_CHECK_EN for byte addressing with a misalignment error; the default build uses word indices.
module y86_dmem_responder #(
  parameter int DEPTH   = 8192,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  lat_cnt;
  logic [63:0] mem [DEPTH];
  logic [63:0] rdata_q;
  logic        err_q;
  logic [63:0] index;
  logic [AW-1:0] mem_idx;
  logic        addr_ok;
  logic        accept;

`ifdef DMEM_ALIGN_CHECK_EN
  assign index   = {3'b000, req_addr[63:3]};
  assign addr_ok = (req_addr[2:0] == 3'b000) && (index < 64'(DEPTH));
`else
  assign index   = req_addr;
  assign addr_ok = index < 64'(DEPTH);
`endif

  // The whole 64-bit index takes part in the range check, so truncating here can never alias.
  assign mem_idx = index[AW-1:0];
  assign accept  = req_valid && req_ready && (state == IDLE);

  // NOTE: the storage array and its read register carry no reset, so they map onto plain RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (req_wr && addr_ok) mem[mem_idx] <= req_wdata;
      rdata_q <= (!req_wr && addr_ok) ? mem[mem_idx] : '0;
      err_q   <= !addr_ok;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
      lat_cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (LATENCY <= 1) begin
              state   <= RESP;
              lat_cnt <= '0;
            end else begin
              state   <= BUSY;
              lat_cnt <= 4'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt <= 4'd1) state <= RESP;
        end
        RESP: begin
          // The first RESP cycle publishes the response; it then holds until the requester takes it.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
            resp_rdata <= rdata_q;
            resp_error <= err_q;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
